alu16_reg: RTL and testbench
============================

Name: alu16_reg

Overview:
- 16-bit integer ALU for the datapath execute stage.
- Computes a result and five condition flags from operands A and B under a 5-bit opcode.
- Registers both the result and the flags on the rising clock edge.
- Flags feed the branch/condition logic, so ops that do not affect a flag must preserve it.

Parameters:
- WIDTH, 16, operand/result width; all values below assume 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A (Rdest)
- B  input  WIDTH  operand B (Rsrc/immediate)
- Opcode  input  5  operation select
- C  output  WIDTH  registered result
- Flags  output  5  registered flags: [4]=Z, [3]=C, [2]=F, [1]=N, [0]=L

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, async): C=0, Flags=0. Outputs remain 0 until the first clock edge after rst_n rises.
- Latency: inputs are sampled at a rising clk edge; C/Flags are valid immediately after that edge (1 cycle). No handshake; a new op is accepted every cycle.
- Reset asserted mid-operation clears C and Flags immediately; any in-flight result is discarded.
- Arithmetic is 17-bit internal; results wrap modulo 2^16.
- Z: result==0. N: result[15]. Unlisted flags hold their previous value.
- Opcode map:
  - 0 ADDU: C=A+B. Updates Z, C=carry-out, N. Clears F.
  - 1 ADD: C=A+B. Updates Z, C=carry-out, N. F=signed overflow (operand signs equal, result sign differs).
  - 2 ADDC: C=A+B+Flags.C. Same flag rules as ADD.
  - 3 SUB: C=A-B. Updates Z, N. C=borrow (A<B unsigned). F=signed overflow (operand signs differ, result sign differs from A).
  - 4 CMP: C holds. Z=(A==B), N=signed A<B, L=unsigned A<B. Clears C and F.
  - 5 CMPU: C holds. Z=(A==B), L=unsigned A<B, N=0. Clears C and F.
  - 6 AND, 7 OR, 8 XOR: bitwise. Update Z, N.
  - 9 NOT: C=~A. Updates Z, N.
  - 10 LSH: shift count s=B[4:0] as signed (-16..15). s>0 shifts A left by s; s<0 shifts A logically right by -s; |s|>=16 gives 0. Updates Z, N.
  - 11 ASH: as LSH, but right shifts replicate A[15]. Updates Z, N.
  - 12 MOV: C=B. No flag change.
  - 13 LUI: C={B[7:0],8'h00}. No flag change.
  - 31 NOP, and all other codes: C and Flags hold.
- All five flags are computed from the same-cycle operands. There are no hazards inside the block.

Test Plan:
- Reset, then NOP (31) with A=B=0 -> C=0000, Flags(ZCFNL)=00000. Assert rst_n=0 mid-stream -> C and Flags clear immediately, without waiting for clk.
- ADD 7FFF+0001 -> C=8000, Flags=00110. Then ADDU FFFF+0001 -> C=0000, Flags=11000.
- SUB 8000-0001 -> C=7FFF, Flags=00100. Then SUB 0000-0001 -> C=FFFF, Flags=01010.
- CMP FFFE vs 0001 -> C stays FFFF, Flags=00010. Then CMPU 0001 vs FFFF -> C stays FFFF, Flags=00001. CMP 1234 vs 1234 -> Flags=10000.
- ADDC with C flag=1: 0001+0001 -> C=0003. LSH A=0001, B=0004 -> C=0010. LSH A=8000, B=1F (-1) -> C=4000. ASH A=8000, B=1F -> C=C000. LUI B=00AB -> C=AB00, flags unchanged.
- Random: 1000 random A/B/opcode triples checked against a reference model every cycle, with 1-cycle latency and flag-hold rules applied.

Source files
------------

// File: rtl/alu16_reg.sv
// alu16_reg: 16-bit execute-stage ALU with registered result and ZCFNL flags.
// The result and flags update one clock after the operands are presented.
// Flags that an operation does not touch keep their previous value.
module alu16_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Opcode,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       Flags
);

  // Opcode encodings
  localparam logic [4:0] OP_ADDU = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDC = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_CMP  = 5'd4;
  localparam logic [4:0] OP_CMPU = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_NOT  = 5'd9;
  localparam logic [4:0] OP_LSH  = 5'd10;
  localparam logic [4:0] OP_ASH  = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_LUI  = 5'd13;

  // Flag bit positions inside Flags
  localparam int FZ = 4;
  localparam int FC = 3;
  localparam int FF = 2;
  localparam int FN = 1;
  localparam int FL = 0;

  // Shift distances cover 0..WIDTH-1; one extra count bit carries the sign
  localparam int SH_BITS = $clog2(WIDTH);
  localparam int HALF    = WIDTH / 2;

  logic [WIDTH-1:0] r_c;
  logic [4:0]       r_flags;

  logic [WIDTH-1:0] w_c_next;
  logic [4:0]       w_flags_next;

  // Adder / subtractor share the 17-bit internal width
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;

  // Shifter
  logic [SH_BITS:0] w_cnt;
  logic             w_neg;
  logic [SH_BITS:0] w_mag;
  logic             w_fill;
  logic [WIDTH-1:0] w_lsh_stage [0:SH_BITS];
  logic [WIDTH-1:0] w_rsh_stage [0:SH_BITS];
  logic [WIDTH-1:0] w_shift_res;

  logic [WIDTH-1:0] w_logic_res;
  logic             w_is_logic;

  // Carry-in only comes from the stored C flag on ADDC
  assign w_cin  = (Opcode == OP_ADDC) ? r_flags[FC] : 1'b0;
  assign w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = {1'b0, A} - {1'b0, B};

  // Add overflows when both operands share a sign the result does not
  assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  // Subtract overflows when operand signs differ and the result flips away from A
  assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

  // Signed shift count: negative values mean a right shift by the magnitude
  assign w_cnt  = B[SH_BITS:0];
  assign w_neg  = w_cnt[SH_BITS];
  assign w_mag  = w_neg ? ({(SH_BITS+1){1'b0}} - w_cnt) : w_cnt;
  assign w_fill = (Opcode == OP_ASH) ? A[WIDTH-1] : 1'b0;

  assign w_lsh_stage[0] = A;
  assign w_rsh_stage[0] = A;

  // Logarithmic barrel shifters, one stage per count bit
  generate
    for (genvar gi = 0; gi < SH_BITS; gi++) begin : g_shift
      localparam int SH = 1 << gi;
      assign w_lsh_stage[gi+1] = w_mag[gi] ? {w_lsh_stage[gi][WIDTH-1-SH:0], {SH{1'b0}}}
                                           : w_lsh_stage[gi];
      assign w_rsh_stage[gi+1] = w_mag[gi] ? {{SH{w_fill}}, w_rsh_stage[gi][WIDTH-1:SH]}
                                           : w_rsh_stage[gi];
    end
  endgenerate

  // A magnitude of WIDTH or more empties the word in either direction
  assign w_shift_res = w_mag[SH_BITS] ? {WIDTH{1'b0}}
                     : (w_neg ? w_rsh_stage[SH_BITS] : w_lsh_stage[SH_BITS]);

  // Bitwise unit; also reports whether the opcode is one of its ops
  always_comb begin
    w_logic_res = {WIDTH{1'b0}};
    w_is_logic  = 1'b1;
    case (Opcode)
      OP_AND:         w_logic_res = A & B;
      OP_OR:          w_logic_res = A | B;
      OP_XOR:         w_logic_res = A ^ B;
      OP_NOT:         w_logic_res = ~A;
      OP_LSH, OP_ASH: w_logic_res = w_shift_res;
      default:        w_is_logic  = 1'b0;
    endcase
  end

  // Next result and flags; everything holds unless the opcode says otherwise
  always_comb begin
    w_c_next     = r_c;
    w_flags_next = r_flags;
    case (Opcode)
      OP_ADDU: begin
        w_c_next         = w_sum[WIDTH-1:0];
        w_flags_next[FZ] = (w_sum[WIDTH-1:0] == '0);
        w_flags_next[FC] = w_sum[WIDTH];
        w_flags_next[FF] = 1'b0;
        w_flags_next[FN] = w_sum[WIDTH-1];
      end
      OP_ADD, OP_ADDC: begin
        w_c_next         = w_sum[WIDTH-1:0];
        w_flags_next[FZ] = (w_sum[WIDTH-1:0] == '0);
        w_flags_next[FC] = w_sum[WIDTH];
        w_flags_next[FF] = w_add_ovf;
        w_flags_next[FN] = w_sum[WIDTH-1];
      end
      OP_SUB: begin
        w_c_next         = w_diff[WIDTH-1:0];
        w_flags_next[FZ] = (w_diff[WIDTH-1:0] == '0);
        w_flags_next[FC] = w_diff[WIDTH];
        w_flags_next[FF] = w_sub_ovf;
        w_flags_next[FN] = w_diff[WIDTH-1];
      end
      OP_CMP: begin
        w_flags_next[FZ] = (A == B);
        w_flags_next[FC] = 1'b0;
        w_flags_next[FF] = 1'b0;
        w_flags_next[FN] = ($signed(A) < $signed(B));
        w_flags_next[FL] = (A < B);
      end
      OP_CMPU: begin
        w_flags_next[FZ] = (A == B);
        w_flags_next[FC] = 1'b0;
        w_flags_next[FF] = 1'b0;
        w_flags_next[FN] = 1'b0;
        w_flags_next[FL] = (A < B);
      end
      OP_MOV: w_c_next = B;
      OP_LUI: w_c_next = {B[HALF-1:0], {HALF{1'b0}}};
      default: begin
        if (w_is_logic) begin
          w_c_next         = w_logic_res;
          w_flags_next[FZ] = (w_logic_res == '0);
          w_flags_next[FN] = w_logic_res[WIDTH-1];
        end
      end
    endcase
  end

  // Output registers; reset clears them without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c     <= {WIDTH{1'b0}};
      r_flags <= 5'b0;
    end else begin
      r_c     <= w_c_next;
      r_flags <= w_flags_next;
    end
  end

  assign C     = r_c;
  assign Flags = r_flags;

endmodule

// File: tb/tb_alu16_reg.sv
// tb_alu16_reg: directed vector table, reset corner cases and a random
// run against a behavioural model of alu16_reg.
module tb_alu16_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [4:0]  Opcode;
  logic [15:0] C;
  logic [4:0]  Flags;

  int total = 0;
  int bad   = 0;

  alu16_reg #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
    .C      (C),
    .Flags  (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [4:0]  f;   // ZCFNL
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge capture, sample 1 ns later
  task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    Opcode = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model, written independently of the RTL structure
  task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       inout logic [15:0] mc, inout logic [4:0] mf);
    int          s;
    int          ua;
    int          ub;
    int          r;
    logic [15:0] res;
    ua = int'(a);
    ub = int'(b);
    res = mc;
    case (op)
      5'd0, 5'd1, 5'd2: begin
        r = ua + ub + ((op == 5'd2) ? int'(mf[3]) : 0);
        res = r[15:0];
        mf[4] = (res == 16'h0);
        mf[3] = (r > 65535);
        mf[2] = (op == 5'd0) ? 1'b0 : ((a[15] == b[15]) && (res[15] != a[15]));
        mf[1] = res[15];
      end
      5'd3: begin
        r = ua - ub;
        res = r[15:0];
        mf[4] = (res == 16'h0);
        mf[3] = (ua < ub);
        mf[2] = (a[15] != b[15]) && (res[15] != a[15]);
        mf[1] = res[15];
      end
      5'd4, 5'd5: begin
        mf[4] = (ua == ub);
        mf[3] = 1'b0;
        mf[2] = 1'b0;
        mf[1] = (op == 5'd4) ? (int'($signed(a)) < int'($signed(b))) : 1'b0;
        mf[0] = (ua < ub);
      end
      5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        case (op)
          5'd6:    res = a & b;
          5'd7:    res = a | b;
          5'd8:    res = a ^ b;
          5'd9:    res = ~a;
          default: begin
            s = b[4] ? int'(b[4:0]) - 32 : int'(b[4:0]);
            if (s >= 16 || s <= -16) res = 16'h0;
            else if (s >= 0) res = a << s;
            else begin
              res = a;
              for (int k = 0; k < -s; k++)
                res = {((op == 5'd11) ? a[15] : 1'b0), res[15:1]};
            end
          end
        endcase
        mf[4] = (res == 16'h0);
        mf[1] = res[15];
      end
      5'd12: res = b;
      5'd13: res = {b[7:0], 8'h00};
      default: ;
    endcase
    mc = res;
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [4:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.f = f;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] mc;
    logic [4:0]  mf;
    logic [4:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;

    // Sequential vectors: flags carry from one row to the next
    vecs[0]  = mk(5'd31, 16'h0000, 16'h0000, 16'h0000, 5'b00000);
    vecs[1]  = mk(5'd1,  16'h7FFF, 16'h0001, 16'h8000, 5'b00110);
    vecs[2]  = mk(5'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
    vecs[3]  = mk(5'd3,  16'h8000, 16'h0001, 16'h7FFF, 5'b00100);
    vecs[4]  = mk(5'd3,  16'h0000, 16'h0001, 16'hFFFF, 5'b01010);
    vecs[5]  = mk(5'd4,  16'hFFFE, 16'h0001, 16'hFFFF, 5'b00010);
    vecs[6]  = mk(5'd5,  16'h0001, 16'hFFFF, 16'hFFFF, 5'b00001);
    vecs[7]  = mk(5'd4,  16'h1234, 16'h1234, 16'hFFFF, 5'b10000);
    vecs[8]  = mk(5'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
    vecs[9]  = mk(5'd2,  16'h0001, 16'h0001, 16'h0003, 5'b00000);
    vecs[10] = mk(5'd10, 16'h0001, 16'h0004, 16'h0010, 5'b00000);
    vecs[11] = mk(5'd10, 16'h8000, 16'h001F, 16'h4000, 5'b00000);
    vecs[12] = mk(5'd11, 16'h8000, 16'h001F, 16'hC000, 5'b00010);
    vecs[13] = mk(5'd13, 16'h5555, 16'h00AB, 16'hAB00, 5'b00010);
    vecs[14] = mk(5'd12, 16'h0000, 16'h5A5A, 16'h5A5A, 5'b00010);
    vecs[15] = mk(5'd6,  16'hF0F0, 16'h0F0F, 16'h0000, 5'b10000);
    vecs[16] = mk(5'd7,  16'hF0F0, 16'h0F0F, 16'hFFFF, 5'b00010);
    vecs[17] = mk(5'd8,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b10000);
    vecs[18] = mk(5'd9,  16'h0000, 16'h0000, 16'hFFFF, 5'b00010);
    vecs[19] = mk(5'd10, 16'h1234, 16'h0010, 16'h0000, 5'b10000);
    vecs[20] = mk(5'd10, 16'h0001, 16'h000F, 16'h8000, 5'b00010);
    vecs[21] = mk(5'd20, 16'h0001, 16'h0001, 16'h8000, 5'b00010);
    vecs[22] = mk(5'd2,  16'h7FFF, 16'h0000, 16'h7FFF, 5'b00000);
    vecs[23] = mk(5'd1,  16'h8000, 16'h8000, 16'h0000, 5'b11100);
    vecs[24] = mk(5'd2,  16'h7FFF, 16'h0000, 16'h8000, 5'b00110);
    vecs[25] = mk(5'd5,  16'h0001, 16'h0002, 16'h8000, 5'b00001);
    vecs[26] = mk(5'd3,  16'h0005, 16'h0003, 16'h0002, 5'b00001);
    vecs[27] = mk(5'd11, 16'h4000, 16'h001E, 16'h1000, 5'b00001);
    vecs[28] = mk(5'd4,  16'h8000, 16'h0001, 16'h1000, 5'b00010);

    rst_n  = 1'b0;
    A      = 16'h0;
    B      = 16'h0;
    Opcode = 5'd31;
    #2;
    chk16("reset_c", C, 16'h0000);
    chk5("reset_flags", Flags, 5'b00000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      $display("vec %0d op=%0d a=%h b=%h -> c=%h flags=%b", i, vecs[i].op, vecs[i].a, vecs[i].b, C, Flags);
      chk16($sformatf("vec%0d_c", i), C, vecs[i].c);
      chk5($sformatf("vec%0d_flags", i), Flags, vecs[i].f);
    end

    // Mid-stream reset: clears between clock edges and holds through an edge
    do_op(5'd1, 16'h7FFF, 16'h0001);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: c=%h flags=%b", C, Flags);
    chk16("async_rst_c", C, 16'h0000);
    chk5("async_rst_flags", Flags, 5'b00000);
    Opcode = 5'd1;
    A      = 16'h0001;
    B      = 16'h0001;
    @(posedge clk);
    #1;
    chk16("rst_hold_c", C, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk16("rst_release_c", C, 16'h0000);
    @(posedge clk);
    #1;
    $display("after release: c=%h flags=%b", C, Flags);
    chk16("first_op_c", C, 16'h0002);
    chk5("first_op_flags", Flags, 5'b00000);

    // Random operations checked every cycle against the model
    mc = 16'h0002;
    mf = 5'b00000;
    for (int i = 0; i < 1000; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      model(rop, ra, rb, mc, mf);
      do_op(rop, ra, rb);
      $display("rnd %0d op=%0d a=%h b=%h -> c=%h flags=%b", i, rop, ra, rb, C, Flags);
      chk16($sformatf("rnd%0d_c", i), C, mc);
      chk5($sformatf("rnd%0d_flags", i), Flags, mf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
